reg_bank_bist: RTL and testbench

//  Initiator-side self-test controller for the 32x32 register bank.

---
 rtl/reg_bank_pkg.sv | 33 +++
 rtl/reg_bank_bist_if.sv | 37 +++
 rtl/reg_bank_bist.sv | 164 ++++++++++++++++
 tb/tb_reg_bank_bist.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the register-bank self-test controller and its bench.
//   DATA_W / ADDR_W / NUM_REGS : bank geometry (32 registers x 32 bits)
//   SEED                       : default pattern seed
//   state_t                    : BIST controller FSM encoding
//   pat(a, ph, seed)           : test pattern, P0 for ph=0 and its complement P1
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_REGS = 32;
    localparam logic [31:0] SEED     = 32'hA5A5_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Multiplying by 0x01010101 replicates the address byte into every byte
    // lane, so neighbouring registers differ in all four lanes.
    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] a,
                                              input logic              ph,
                                              input logic [DATA_W-1:0] seed);
        logic [DATA_W-1:0] p0;
        p0 = seed ^ (a * 32'h0101_0101);
        return ph ? ~p0 : p0;
    endfunction

endpackage

// File: rtl/reg_bank_bist_if.sv
// -----------------------------------------------------------------------------
// reg_bank_bist_if
// Bus between the self-test controller (master) and the register bank (slave).
//   en          : write enable
//   write_reg   : write address
//   write_data  : write data
//   read_reg    : read address
//   read_data   : read data, combinational from read_reg
// -----------------------------------------------------------------------------
interface reg_bank_bist_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg;
    logic [DATA_W-1:0] read_data;

    modport master (
        output en,
        output write_reg,
        output write_data,
        output read_reg,
        input  read_data
    );

    modport slave (
        input  en,
        input  write_reg,
        input  write_data,
        input  read_reg,
        output read_data
    );

endinterface

// File: rtl/reg_bank_bist.sv
// -----------------------------------------------------------------------------
// reg_bank_bist
// Self-test controller for the 32x32 register bank. Writes a pattern into every
// register, reads it back, then repeats with the complemented pattern. Stops at
// the first mismatch and reports the failing register and the data read.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   start      : begin a test (only looked at while idle)
//   busy       : test in progress
//   done       : one-cycle pulse at the end of a test
//   pass       : result of the last test, held until the next start
//   fail_addr  : first mismatching register (0 if none)
//   fail_data  : read_data captured at the first mismatch
//   bank       : reg_bank_bist_if master (en/write_reg/write_data/read_reg/read_data)
//
// Build option
//   BIST_SKIP_R0_EN : register 0 is hardwired zero; its expected value is 0 in
//                     both phases (the writes to it are still issued).
// -----------------------------------------------------------------------------
module reg_bank_bist #(
    parameter int          DATA_W   = reg_bank_pkg::DATA_W,
    parameter int          ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int          NUM_REGS = reg_bank_pkg::NUM_REGS,
    parameter logic [31:0] SEED     = reg_bank_pkg::SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_data,
    reg_bank_bist_if.master     bank
);

    import reg_bank_pkg::*;

    // One extra counter bit so NUM_REGS = 2**ADDR_W reaches its terminal
    // compare without wrapping.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);

    state_t            state;
    logic              ph;
    logic [ADDR_W:0]   addr;
    logic [ADDR_W:0]   addr_nxt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_reg;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] expect_val(input logic [ADDR_W-1:0] a,
                                                     input logic              p);
`ifdef BIST_SKIP_R0_EN
        if (a == '0) begin
            return '0;
        end
`endif
        return pat(DATA_W'(a), p, SEED);
    endfunction

    assign addr_nxt = addr + 1'b1;
    assign mismatch = (bank.read_data != expect_val(rd_reg, ph));

    assign bank.en         = wr_en;
    assign bank.write_reg  = wr_reg;
    assign bank.write_data = wr_data;
    assign bank.read_reg   = rd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ph        <= 1'b0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            rd_reg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_WRITE;
                        ph        <= 1'b0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        wr_en     <= 1'b1;
                        wr_reg    <= '0;
                        wr_data   <= pat('0, 1'b0, SEED);
                    end
                end

                // addr is the register currently presented on the write port.
                ST_WRITE: begin
                    if (addr == LAST) begin
                        state  <= ST_READ;
                        wr_en  <= 1'b0;
                        addr   <= '0;
                        rd_reg <= '0;
                    end else begin
                        addr    <= addr_nxt;
                        wr_reg  <= ADDR_W'(addr_nxt);
                        wr_data <= pat(DATA_W'(addr_nxt), ph, SEED);
                    end
                end

                // read_reg has been stable for the whole cycle, so read_data
                // is settled at this edge.
                ST_READ: begin
                    if (mismatch) begin
                        state     <= ST_DONE;
                        fail_addr <= rd_reg;
                        fail_data <= bank.read_data;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (addr == LAST) begin
                        if (!ph) begin
                            state   <= ST_WRITE;
                            ph      <= 1'b1;
                            addr    <= '0;
                            wr_en   <= 1'b1;
                            wr_reg  <= '0;
                            wr_data <= pat('0, 1'b1, SEED);
                        end else begin
                            state <= ST_DONE;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        addr   <= addr_nxt;
                        rd_reg <= ADDR_W'(addr_nxt);
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_bist.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_bist
// Bench for reg_bank_bist: a behavioural 32x32 register bank with injectable
// stuck-at bits and an optional hardwired-zero register 0, directed scenarios
// plus randomized fault/start-pulse runs, and a reference model that walks the
// pattern rules to predict the test outcome.
// -----------------------------------------------------------------------------
module tb_reg_bank_bist;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef BIST_SKIP_R0_EN
    localparam bit SKIP_R0 = 1'b1;
`else
    localparam bit SKIP_R0 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    reg_bank_bist_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_bank_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .bank      (bus)
    );

    always #5 clk = ~clk;

    // Behavioural bank with fault injection on the read side.
    logic [DW-1:0] mem [NR];
    bit            r0_zero = SKIP_R0;
    int            flt_reg = -1;
    logic [DW-1:0] m0 = '0;
    logic [DW-1:0] m1 = '0;
    logic [DW-1:0] rd;

    always @(posedge clk) begin
        if (bus.en) mem[bus.write_reg] <= bus.write_data;
    end

    always_comb begin
        rd = mem[bus.read_reg];
        if (int'(bus.read_reg) == flt_reg) rd = (rd & ~m0) | m1;
        if (r0_zero && bus.read_reg == '0) rd = '0;
    end

    assign bus.read_data = rd;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] tb_pat(input int a, input bit ph);
        logic [DW-1:0] v;
        v = 32'hA5A5_0000 ^ (32'(a) * 32'h0101_0101);
        return ph ? ~v : v;
    endfunction

    function automatic logic [DW-1:0] bank_view(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (a == flt_reg) r = (r & ~m0) | m1;
        if (r0_zero && a == 0) r = '0;
        return r;
    endfunction

    // Walk both phases over all registers; first disagreement decides the run.
    task automatic ref_model(output bit p, output int fa, output logic [DW-1:0] fd,
                             output int busy_n, output int en_n);
        logic [DW-1:0] want, seen;
        bit found;
        p = 1'b1; fa = 0; fd = '0; busy_n = 4 * NR; en_n = 2 * NR; found = 0;
        for (int ph = 0; ph < 2 && !found; ph++) begin
            for (int a = 0; a < NR && !found; a++) begin
                seen = bank_view(a, tb_pat(a, ph[0]));
                want = (SKIP_R0 && a == 0) ? '0 : tb_pat(a, ph[0]);
                if (seen !== want) begin
                    found = 1; p = 1'b0; fa = a; fd = seen;
                    busy_n = ph * 2 * NR + NR + a + 1;
                    en_n = (ph + 1) * NR;
                end
            end
        end
    endtask

    task automatic run_test(input string name, input int rp1, input int rp2, input bit rp_done);
        bit            e_pass;
        int            e_fa, e_busy, e_en;
        logic [DW-1:0] e_fd;
        int            done_cyc, bcnt, ecnt, ebad, dcnt;
        bit            seen15;
        logic [DW-1:0] w15;
        ref_model(e_pass, e_fa, e_fd, e_busy, e_en);
        done_cyc = 0; bcnt = 0; ecnt = 0; ebad = 0; dcnt = 0; seen15 = 0; w15 = '0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 600 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == rp1) || (cyc == rp2);
            if (busy) bcnt++;
            if (bus.en) ecnt++;
            if (bus.en && !busy) ebad++;
            if (bus.en && bus.write_reg == 5'd15 && !seen15) begin
                seen15 = 1; w15 = bus.write_data;
            end
            if (done) begin
                done_cyc = cyc; dcnt++;
                chk({name, "/busy_at_done"}, 64'(busy), 64'd0);
                start = rp_done;
            end
        end
        chk({name, "/done_cycle"}, 64'(done_cyc), 64'(e_busy + 1));
        chk({name, "/busy_cycles"}, 64'(bcnt), 64'(e_busy));
        chk({name, "/en_cycles"}, 64'(ecnt), 64'(e_en));
        chk({name, "/en_while_idle"}, 64'(ebad), 64'd0);
        chk({name, "/write_r15_ph0"}, 64'(w15), 64'h0000_0000_AAAA_0F0F);
        chk({name, "/pass"}, 64'(pass), 64'(e_pass));
        chk({name, "/fail_addr"}, 64'(fail_addr), 64'(e_fa));
        chk({name, "/fail_data"}, 64'(fail_data), 64'(e_fd));
        @(negedge clk);
        start = 1'b0;
        if (done) dcnt++;
        chk({name, "/busy_after_done"}, 64'(busy), 64'd0);
        chk({name, "/pass_held"}, 64'(pass), 64'(e_pass));
        @(negedge clk);
        if (done) dcnt++;
        chk({name, "/done_pulses"}, 64'(dcnt), 64'd1);
        chk({name, "/start_in_done_ignored"}, 64'(busy), 64'd0);
        if (done_cyc == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int kind;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/pass", 64'(pass), 64'd0);
        chk("rst/fail_addr", 64'(fail_addr), 64'd0);
        chk("rst/fail_data", 64'(fail_data), 64'd0);
        chk("rst/en", 64'(bus.en), 64'd0);
        chk("rst/write_reg", 64'(bus.write_reg), 64'd0);
        chk("rst/write_data", 64'(bus.write_data), 64'd0);
        chk("rst/read_reg", 64'(bus.read_reg), 64'd0);
        rst = 1'b0;

        run_test("healthy", 0, 0, 1'b0);

        flt_reg = 10; m0 = 32'h8; m1 = '0;
        run_test("sa0_r10b3", 0, 0, 1'b0);
        flt_reg = -1; m0 = '0;

        // Reset in the middle of the write burst.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/en", 64'(bus.en), 64'd0);
        chk("midrst/busy", 64'(busy), 64'd0);
        chk("midrst/done", 64'(done), 64'd0);
        chk("midrst/write_reg", 64'(bus.write_reg), 64'd0);
        chk("midrst/write_data", 64'(bus.write_data), 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst/en_later", 64'(bus.en), 64'd0);
        chk("midrst/busy_later", 64'(busy), 64'd0);
        run_test("after_rst", 0, 0, 1'b0);

        run_test("repulse", 5, 70, 1'b1);

        r0_zero = 1'b1;
        run_test("r0_zero", 0, 0, 1'b0);
        r0_zero = SKIP_R0;

        for (int t = 0; t < 10; t++) begin
            kind = int'($urandom_range(0, 2));
            flt_reg = (kind == 0) ? -1 : int'($urandom_range(0, NR - 1));
            m0 = (kind == 1) ? (32'h1 << $urandom_range(0, DW - 1)) : '0;
            m1 = (kind == 2) ? (32'h1 << $urandom_range(0, DW - 1)) : '0;
            run_test($sformatf("rand%0d", t), int'($urandom_range(2, 32)),
                     int'($urandom_range(2, 32)), $urandom_range(0, 1) == 1);
        end
        flt_reg = -1; m0 = '0; m1 = '0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
